// File: rtl/av_arb_pkg.sv
// Shared types and defaults for the Avalon-MM two-port arbiter.
package av_arb_pkg;

    // Default largest instruction-refill burst accepted from the I-port.
    localparam int unsigned MAX_BURST_DEFAULT = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RD_WAIT
    } arb_state_t;

    // Port that owns (or last owned) the shared bus.
    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin decision: on a tie, the port not granted last wins.
// req[0]/grant[0] is the instruction port, req[1]/grant[1] the data port.
module rr_arbiter2
    import av_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    // One-hot grant; a tie is broken against the previous owner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/av_port_arbiter.sv
// Shares one Avalon-MM master between an instruction-refill port (bursting
// reads) and a data port (single-beat reads/writes). Read data returns with
// zero-cycle latency to the port that issued the read.
// BCW must satisfy 2**BCW > MAX_BURST.
module av_port_arbiter
    import av_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned BCW       = 3
) (
    input  logic            clk,
    input  logic            resetn,
    // Instruction port
    input  logic [31:0]     i_address,
    input  logic            i_read,
    input  logic [BCW-1:0]  i_burstcount,
    output logic            i_waitrequest,
    output logic [31:0]     i_readdata,
    output logic            i_readdatavalid,
    // Data port
    input  logic [31:0]     d_address,
    input  logic            d_read,
    input  logic            d_write,
    input  logic [31:0]     d_writedata,
    input  logic [3:0]      d_byteenable,
    output logic            d_waitrequest,
    output logic [31:0]     d_readdata,
    output logic            d_readdatavalid,
    // Shared Avalon-MM master
    output logic [31:0]     av_address,
    output logic            av_read,
    output logic            av_write,
    output logic [31:0]     av_writedata,
    output logic [3:0]      av_byteenable,
    output logic [BCW-1:0]  av_burstcount,
    output logic            av_beginbursttransfer,
    input  logic            av_waitrequest,
    input  logic [31:0]     av_readdata,
    input  logic            av_readdatavalid
);

    localparam logic [BCW-1:0] MAX_BC = BCW'(MAX_BURST);
    localparam logic [BCW-1:0] ONE_BC = BCW'(1);

    arb_state_t     state_q, state_d, cur_state;
    logic [BCW-1:0] count_q, count_d;
    owner_t         owner_q, owner_d;
    owner_t         last_grant_q, last_grant_d;
    logic           first_q, first_d;
    logic [1:0]     grant;
    logic [BCW-1:0] i_eff_bc;

    // Requested burst length with 0 promoted to 1 and oversize clamped.
    always_comb begin
        if (i_burstcount == '0) begin
            i_eff_bc = ONE_BC;
        end else if (i_burstcount > MAX_BC) begin
            i_eff_bc = MAX_BC;
        end else begin
            i_eff_bc = i_burstcount;
        end
    end

    rr_arbiter2 u_rr (
        .req        ({d_read | d_write, i_read}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Treat the block as idle while reset is held so every output is quiet
    // even before the first reset edge has cleaned up the state register.
    assign cur_state = resetn ? state_q : IDLE;

    // Read data is broadcast; only the readdatavalid strobes are routed.
    assign i_readdata = av_readdata;
    assign d_readdata = av_readdata;

    // Next-state, register updates and the command/response muxing.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves one unassigned (which would infer a latch).
        state_d               = cur_state;
        count_d               = count_q;
        owner_d               = owner_q;
        last_grant_d          = last_grant_q;
        av_address            = '0;
        av_read               = 1'b0;
        av_write              = 1'b0;
        av_writedata          = '0;
        av_byteenable         = '0;
        av_burstcount         = '0;
        av_beginbursttransfer = 1'b0;
        i_waitrequest         = 1'b1;
        d_waitrequest         = 1'b1;
        i_readdatavalid       = 1'b0;
        d_readdatavalid       = 1'b0;

        case (cur_state)
            IDLE: begin
                if (grant[0]) begin
                    state_d = GRANT_I;
                end else if (grant[1]) begin
                    state_d = GRANT_D;
                end
            end

            GRANT_I: begin
                av_address            = i_address;
                av_read               = i_read;
                av_byteenable         = 4'hF;
                av_burstcount         = i_eff_bc;
                av_beginbursttransfer = first_q & i_read;
                i_waitrequest         = av_waitrequest;
                if (!i_read) begin
                    state_d = IDLE;
                end else if (!av_waitrequest) begin
                    last_grant_d = OWN_I;
                    owner_d      = OWN_I;
                    count_d      = i_eff_bc;
                    state_d      = RD_WAIT;
                end
            end

            GRANT_D: begin
                av_address            = d_address;
                av_write              = d_write;
                av_read               = d_read & ~d_write;
                av_writedata          = d_writedata;
                av_byteenable         = d_byteenable;
                av_burstcount         = ONE_BC;
                av_beginbursttransfer = first_q & (d_read | d_write);
                d_waitrequest         = av_waitrequest;
                if (!(d_read || d_write)) begin
                    state_d = IDLE;
                end else if (!av_waitrequest) begin
                    last_grant_d = OWN_D;
                    if (d_write) begin
                        state_d = IDLE;
                    end else begin
                        owner_d = OWN_D;
                        count_d = ONE_BC;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (av_readdatavalid) begin
                    i_readdatavalid = (owner_q == OWN_I);
                    d_readdatavalid = (owner_q == OWN_D);
                    count_d         = count_q - ONE_BC;
                    if (count_q == ONE_BC) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // The first cycle of a grant visit is the cycle after leaving IDLE.
        first_d = (cur_state == IDLE) && ((state_d == GRANT_I) || (state_d == GRANT_D));
    end

    // State register with synchronous active-low reset; a reset abandons any burst.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!resetn) begin
            state_q      <= IDLE;
            count_q      <= '0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
        end
    end

endmodule

// File: tb/tb_av_port_arbiter.sv
// Self-checking bench for av_port_arbiter: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized traffic compared every
// cycle against a transaction-level reference model.
module tb_av_port_arbiter;

    localparam int MAXB = 4;
    localparam int BCW  = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic [31:0]     i_address;
    logic            i_read;
    logic [BCW-1:0]  i_burstcount;
    logic            i_waitrequest;
    logic [31:0]     i_readdata;
    logic            i_readdatavalid;
    logic [31:0]     d_address;
    logic            d_read;
    logic            d_write;
    logic [31:0]     d_writedata;
    logic [3:0]      d_byteenable;
    logic            d_waitrequest;
    logic [31:0]     d_readdata;
    logic            d_readdatavalid;
    logic [31:0]     av_address;
    logic            av_read;
    logic            av_write;
    logic [31:0]     av_writedata;
    logic [3:0]      av_byteenable;
    logic [BCW-1:0]  av_burstcount;
    logic            av_beginbursttransfer;
    logic            av_waitrequest;
    logic [31:0]     av_readdata;
    logic            av_readdatavalid;

    always #5 clk = ~clk;

    av_port_arbiter #(.MAX_BURST(MAXB), .BCW(BCW)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .i_address             (i_address),
        .i_read                (i_read),
        .i_burstcount          (i_burstcount),
        .i_waitrequest         (i_waitrequest),
        .i_readdata            (i_readdata),
        .i_readdatavalid       (i_readdatavalid),
        .d_address             (d_address),
        .d_read                (d_read),
        .d_write               (d_write),
        .d_writedata           (d_writedata),
        .d_byteenable          (d_byteenable),
        .d_waitrequest         (d_waitrequest),
        .d_readdata            (d_readdata),
        .d_readdatavalid       (d_readdatavalid),
        .av_address            (av_address),
        .av_read               (av_read),
        .av_write              (av_write),
        .av_writedata          (av_writedata),
        .av_byteenable         (av_byteenable),
        .av_burstcount         (av_burstcount),
        .av_beginbursttransfer (av_beginbursttransfer),
        .av_waitrequest        (av_waitrequest),
        .av_readdata           (av_readdata),
        .av_readdatavalid      (av_readdatavalid)
    );

    // Snapshot of every DUT output.
    typedef struct packed {
        logic [31:0]    av_address;
        logic           av_read;
        logic           av_write;
        logic [31:0]    av_writedata;
        logic [3:0]     av_byteenable;
        logic [BCW-1:0] av_burstcount;
        logic           av_begin;
        logic           i_wait;
        logic           i_rdv;
        logic [31:0]    i_rdata;
        logic           d_wait;
        logic           d_rdv;
        logic [31:0]    d_rdata;
    } out_t;

    // Directed vector: inputs then expected control outputs.
    typedef struct packed {
        logic           rst_n;
        logic           ird;
        logic [BCW-1:0] ibc;
        logic           drd;
        logic           dwr;
        logic           avw;
        logic           rdv;
        logic           e_rd;
        logic           e_bg;
        logic [BCW-1:0] e_bc;
        logic           e_iw;
        logic           e_irdv;
        logic           e_dw;
        logic           e_drdv;
    } tv_t;

    int   n_vec = 0;
    int   n_err = 0;
    out_t snap;

    // Reference model: a transaction view of the bus.
    // m_owner: -1 nobody holds a command grant, 0 instruction, 1 data.
    // m_beats: read beats still owed to port m_rdport.
    int m_owner  = -1;
    int m_beats  = 0;
    int m_rdport = 0;
    int m_last   = 1;
    bit m_fresh  = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int eff_bc(input logic [BCW-1:0] bc);
        if (bc == 0) return 1;
        if (int'(bc) > MAXB) return MAXB;
        return int'(bc);
    endfunction

    function automatic out_t get_act();
        out_t o;
        o.av_address    = av_address;
        o.av_read       = av_read;
        o.av_write      = av_write;
        o.av_writedata  = av_writedata;
        o.av_byteenable = av_byteenable;
        o.av_burstcount = av_burstcount;
        o.av_begin      = av_beginbursttransfer;
        o.i_wait        = i_waitrequest;
        o.i_rdv         = i_readdatavalid;
        o.i_rdata       = i_readdata;
        o.d_wait        = d_waitrequest;
        o.d_rdv         = d_readdatavalid;
        o.d_rdata       = d_readdata;
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o = '0;
        o.i_wait  = 1'b1;
        o.d_wait  = 1'b1;
        o.i_rdata = av_readdata;
        o.d_rdata = av_readdata;
        if (resetn) begin
            if (m_owner == 0) begin
                o.av_address    = i_address;
                o.av_read       = i_read;
                o.av_byteenable = 4'hF;
                o.av_burstcount = BCW'(eff_bc(i_burstcount));
                o.av_begin      = m_fresh && i_read;
                o.i_wait        = av_waitrequest;
            end else if (m_owner == 1) begin
                o.av_address    = d_address;
                o.av_write      = d_write;
                o.av_read       = d_read && !d_write;
                o.av_writedata  = d_writedata;
                o.av_byteenable = d_byteenable;
                o.av_burstcount = BCW'(1);
                o.av_begin      = m_fresh && (d_read || d_write);
                o.d_wait        = av_waitrequest;
            end else if (m_beats > 0 && av_readdatavalid) begin
                if (m_rdport == 0) o.i_rdv = 1'b1;
                else               o.d_rdv = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_step();
        bit ri, rd, req;
        ri = i_read;
        rd = d_read || d_write;
        if (!resetn) begin
            m_owner = -1; m_beats = 0; m_last = 1; m_fresh = 1'b0;
        end else if (m_beats > 0) begin
            m_fresh = 1'b0;
            if (av_readdatavalid) m_beats--;
        end else if (m_owner < 0) begin
            if (ri && rd)  m_owner = (m_last == 1) ? 0 : 1;
            else if (ri)   m_owner = 0;
            else if (rd)   m_owner = 1;
            m_fresh = (m_owner >= 0);
        end else begin
            m_fresh = 1'b0;
            req = (m_owner == 0) ? ri : rd;
            if (!req) begin
                m_owner = -1;
            end else if (!av_waitrequest) begin
                m_last = m_owner;
                if (m_owner == 1 && d_write) begin
                    m_owner = -1;
                end else begin
                    m_beats  = (m_owner == 0) ? eff_bc(i_burstcount) : 1;
                    m_rdport = m_owner;
                    m_owner  = -1;
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle(input string name);
        out_t e;
        @(negedge clk);
        snap = get_act();
        e    = model_out();
        check(name, 160'(snap), 160'(e));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        i_read = 1'b0; i_burstcount = '0; d_read = 1'b0; d_write = 1'b0;
        av_waitrequest = 1'b0; av_readdatavalid = 1'b0;
        i_address = 32'h100; d_address = 32'h2000;
        d_writedata = 32'h1234_5678; d_byteenable = 4'hF; av_readdata = 32'hCAFE_0000;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        quiet_inputs();
        cycle("rst");
        cycle("rst");
        resetn = 1'b1;
    endtask

    tv_t tbl[$];
    int  order[$];

    initial begin
        resetn = 1'b0;
        quiet_inputs();

        // rst ird ibc drd dwr avw rdv | rd bg bc iw irdv dw drdv
        tbl.push_back(tv_t'{0,0,0,0,0,0,0, 0,0,0,1,0,1,0}); // in reset
        tbl.push_back(tv_t'{1,1,4,0,0,0,0, 0,0,0,1,0,1,0}); // IDLE sees request
        tbl.push_back(tv_t'{1,1,4,0,0,0,0, 1,1,4,0,0,1,0}); // command at N+1
        tbl.push_back(tv_t'{1,0,4,0,0,0,1, 0,0,0,1,1,1,0}); // beat 1
        tbl.push_back(tv_t'{1,0,4,0,0,0,0, 0,0,0,1,0,1,0}); // bubble
        tbl.push_back(tv_t'{1,0,4,0,0,0,1, 0,0,0,1,1,1,0}); // beat 2
        tbl.push_back(tv_t'{1,0,4,0,0,0,1, 0,0,0,1,1,1,0}); // beat 3
        tbl.push_back(tv_t'{1,0,4,0,0,0,1, 0,0,0,1,1,1,0}); // beat 4
        tbl.push_back(tv_t'{1,0,4,0,0,0,1, 0,0,0,1,0,1,0}); // stray beat in IDLE
        tbl.push_back(tv_t'{1,1,0,0,0,0,0, 0,0,0,1,0,1,0}); // burstcount 0
        tbl.push_back(tv_t'{1,1,0,0,0,0,0, 1,1,1,0,0,1,0});
        tbl.push_back(tv_t'{1,0,0,0,0,0,1, 0,0,0,1,1,1,0}); // the only beat
        tbl.push_back(tv_t'{1,0,0,0,0,0,1, 0,0,0,1,0,1,0}); // second beat ignored
        tbl.push_back(tv_t'{1,1,7,0,0,1,0, 0,0,0,1,0,1,0}); // burstcount 7
        tbl.push_back(tv_t'{1,1,7,0,0,1,0, 1,1,4,1,0,1,0}); // clamped, stalled
        tbl.push_back(tv_t'{1,1,7,0,0,1,0, 1,0,4,1,0,1,0}); // begin only once
        tbl.push_back(tv_t'{1,1,7,0,0,0,0, 1,0,4,0,0,1,0}); // accepted
        tbl.push_back(tv_t'{1,0,7,0,0,0,1, 0,0,0,1,1,1,0}); // beat 1
        tbl.push_back(tv_t'{1,0,7,0,0,0,1, 0,0,0,1,1,1,0}); // beat 2
        tbl.push_back(tv_t'{0,0,7,0,0,0,1, 0,0,0,1,0,1,0}); // reset mid-burst
        tbl.push_back(tv_t'{1,0,7,0,0,0,1, 0,0,0,1,0,1,0}); // stray beat 3
        tbl.push_back(tv_t'{1,0,7,0,0,0,1, 0,0,0,1,0,1,0}); // stray beat 4

        foreach (tbl[k]) begin
            resetn           = tbl[k].rst_n;
            i_read           = tbl[k].ird;
            i_burstcount     = tbl[k].ibc;
            d_read           = tbl[k].drd;
            d_write          = tbl[k].dwr;
            av_waitrequest   = tbl[k].avw;
            av_readdatavalid = tbl[k].rdv;
            av_readdata      = 32'hA000_0000 + 32'(k);
            cycle($sformatf("model_tbl%0d", k));
            check($sformatf("tbl%0d", k),
                  160'({snap.av_read, snap.av_begin, snap.av_burstcount, snap.i_wait,
                        snap.i_rdv, snap.d_wait, snap.d_rdv}),
                  160'({tbl[k].e_rd, tbl[k].e_bg, tbl[k].e_bc, tbl[k].e_iw,
                        tbl[k].e_irdv, tbl[k].e_dw, tbl[k].e_drdv}));
        end

        // Both ports request continuously after reset: I first, then alternate.
        do_reset();
        i_read = 1'b1; i_burstcount = 3'd1; d_read = 1'b1; av_readdatavalid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle("rr");
            if (snap.av_begin) order.push_back((snap.av_address == 32'h100) ? 0 : 1);
        end
        check("rr_count", 160'(order.size() >= 4), 160'(1));
        for (int k = 0; k < 4 && k < order.size(); k++)
            check($sformatf("rr_order%0d", k), 160'(order[k]), 160'(k % 2));

        // Data write stalled by waitrequest for three cycles.
        do_reset();
        d_write = 1'b1; av_waitrequest = 1'b1;
        cycle("wr_idle");
        for (int c = 0; c < 3; c++) begin
            cycle("wr_stall");
            check($sformatf("wr_hold%0d", c),
                  160'({snap.av_write, snap.av_address, snap.av_writedata, snap.d_wait}),
                  160'({1'b1, 32'h2000, 32'h1234_5678, 1'b1}));
        end
        av_waitrequest = 1'b0;
        cycle("wr_accept");
        check("wr_accept", 160'({snap.av_write, snap.d_wait}), 160'(2'b10));
        d_write = 1'b0;
        cycle("wr_after");
        check("wr_idle_after", 160'({snap.av_write, snap.av_read, snap.d_wait}), 160'(3'b001));

        // Data read arriving during an instruction burst.
        do_reset();
        i_read = 1'b1; i_burstcount = 3'd4;
        cycle("ib_idle");
        cycle("ib_grant");
        i_read = 1'b0; d_read = 1'b1; av_readdatavalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cycle("ib_beat");
            check($sformatf("ib_beat%0d", b),
                  160'({snap.d_wait, snap.d_rdv, snap.i_rdv, snap.av_read}), 160'(4'b1010));
        end
        av_readdatavalid = 1'b0;
        cycle("ib_gap");
        check("ib_gap", 160'({snap.av_read, snap.d_wait}), 160'(2'b01));
        cycle("d_issue");
        check("d_issue", 160'({snap.av_read, snap.av_address, snap.av_burstcount, snap.d_wait}),
              160'({1'b1, 32'h2000, 3'd1, 1'b0}));
        d_read = 1'b0; av_readdatavalid = 1'b1;
        cycle("d_beat");
        check("d_beat", 160'({snap.d_rdv, snap.i_rdv}), 160'(2'b10));

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            resetn           = ($urandom_range(0, 63) != 0);
            i_read           = ($urandom_range(0, 3) != 0);
            i_address        = $urandom;
            i_burstcount     = BCW'($urandom_range(0, 7));
            d_read           = 1'($urandom_range(0, 1));
            d_write          = ($urandom_range(0, 3) == 0);
            d_address        = $urandom;
            d_writedata      = $urandom;
            d_byteenable     = 4'($urandom_range(0, 15));
            av_waitrequest   = ($urandom_range(0, 2) == 0);
            av_readdatavalid = 1'($urandom_range(0, 1));
            av_readdata      = $urandom;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/av_port_arbiter.md
AV_PORT_ARBITER -- requirements
Module: av_port_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, meaning the largest read burst length accepted from the instruction port.
REQ-002 Parameter BCW, default 3, meaning the burstcount width, which SHALL satisfy 2^BCW > MAX_BURST.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 i_address / i_read / i_burstcount  input  32/1/BCW  instruction-cache refill read request.
REQ-006 i_waitrequest / i_readdata / i_readdatavalid  output  1/32/1  instruction-port response.
REQ-007 d_address / d_read / d_write / d_writedata / d_byteenable  input  32/1/1/32/4  data-port single-beat request.
REQ-008 d_waitrequest / d_readdata / d_readdatavalid  output  1/32/1  data-port response.
REQ-009 av_address / av_read / av_write / av_writedata / av_byteenable / av_burstcount / av_beginbursttransfer  output  32/1/1/32/4/BCW/1  shared Avalon-MM master command.
REQ-010 av_waitrequest / av_readdata / av_readdatavalid  input  1/32/1  shared Avalon-MM slave response.

Function
REQ-011 The block SHALL use an FSM with states IDLE, GRANT_I, GRANT_D and RD_WAIT.
REQ-012 In IDLE, av_read, av_write and av_beginbursttransfer SHALL be 0, and i_waitrequest and d_waitrequest SHALL be 1.
REQ-013 In IDLE, a single requester (i_read, or d_read|d_write) SHALL be granted on the next edge: IDLE->GRANT_I or IDLE->GRANT_D.
REQ-014 When both ports request in the same IDLE cycle, the block SHALL grant the port not granted last (round-robin via a last_grant register).
REQ-015 In GRANT_x, the owner's command SHALL be muxed combinationally onto av_*, and av_waitrequest SHALL be forwarded to the owner's waitrequest; the non-owner SHALL see waitrequest=1.
REQ-016 Instruction-port commands SHALL drive av_byteenable=4'hF, av_write=0 and av_burstcount=i_burstcount, with i_burstcount 0 treated as 1 and values above MAX_BURST clamped to MAX_BURST.
REQ-017 Data-port commands SHALL drive av_burstcount=1; when d_read and d_write are both high, the command SHALL be treated as a write.
REQ-018 av_beginbursttransfer SHALL be 1 only in the first cycle of each GRANT_x visit.
REQ-019 The command is accepted when (av_read|av_write)&!av_waitrequest, and last_grant SHALL update to the owner on that cycle.
REQ-020 A write acceptance SHALL cause GRANT_D->IDLE.
REQ-021 A read acceptance SHALL cause GRANT_x->RD_WAIT, latching the owner and effective burst length into a beat counter.
REQ-022 In RD_WAIT, each av_readdatavalid SHALL be routed to the latched owner's readdatavalid with av_readdata in the same cycle (zero-cycle latency) and SHALL decrement the counter.
REQ-023 The beat that brings the counter to 0 SHALL cause RD_WAIT->IDLE; no new grant SHALL be issued before the last beat.
REQ-024 i_readdata and d_readdata SHALL carry av_readdata unconditionally; the readdatavalid outputs qualify them.
REQ-025 av_readdatavalid outside RD_WAIT SHALL be ignored and SHALL not be routed to either port.
REQ-026 If the owner deasserts its request in GRANT_x before acceptance, the FSM SHALL return to IDLE with last_grant unchanged.
REQ-027 Minimum grant latency is 1 cycle (request in IDLE at cycle N, av command at N+1); the minimum IDLE gap between transactions is 1 cycle.

Reset
REQ-028 On resetn=0 the state SHALL become IDLE, the beat counter 0, and last_grant DATA (so the instruction port wins the first tie).
REQ-029 During and immediately after reset, all av_* command outputs and readdatavalid outputs SHALL be 0, and both waitrequests SHALL be 1.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; subsequent stray av_readdatavalid beats SHALL be ignored per REQ-025.

Structure
REQ-031 Shared package av_arb_pkg SHALL hold the arb_state_t enum (IDLE, GRANT_I, GRANT_D, RD_WAIT), the owner_t enum (OWN_I, OWN_D) and the MAX_BURST default.
REQ-032 The two-requester round-robin decision SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last_grant; output grant one-hot); the remaining logic SHALL stay flat.

Verification
REQ-033 Instruction only: i_read=1, i_address=0x100, i_burstcount=4, waitrequest low -> av_read and beginbursttransfer at N+1, four beats routed to i_readdatavalid, then IDLE.
REQ-034 Both ports request in IDLE after reset -> instruction port granted first; data port granted on the next arbitration; then alternating while both stay asserted.
REQ-035 Data write d_address=0x2000, d_writedata=0x12345678, av_waitrequest high for 3 cycles -> command held stable and d_waitrequest=1 for 3 cycles; accepted on cycle 4; IDLE next cycle.
REQ-036 d_read during an in-flight instruction burst -> d_waitrequest stays 1 until the fourth beat; data read is issued 2 cycles after the last beat.
REQ-037 i_burstcount=0 -> av_burstcount=1 and exactly one beat is expected; i_burstcount=7 -> clamped to 4.
REQ-038 resetn pulsed low after beat 2 of 4 -> IDLE, both waitrequests 1; the two remaining beats produce no readdatavalid on either port.
